note_player: RTL and testbench

//  Consumer end of the song_reader note interface. Accepts one {note, duration} per
//  new_note/player_ready handshake and holds it for `duration` beats.

---
 rtl/note_player_if.sv | 24 ++
 rtl/note_player.sv | 74 +++++++
 tb/tb_note_player.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/note_player_if.sv
// rtl/note_player_if.sv - song_reader to note_player {note, duration} handshake
interface note_player_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              player_ready;

    modport master (
        output new_note,
        output note,
        output duration,
        input  player_ready
    );

    modport slave (
        input  new_note,
        input  note,
        input  duration,
        output player_ready
    );
endinterface

// File: rtl/note_player.sv
// rtl/note_player.sv - holds one note for its beat count while driving a phase-accumulated square tone
module note_player #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    note_player_if.slave      nif,
    input  logic              play_enable,
    input  logic              beat,
    input  logic [ACC_W-1:0]  freq_step,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_done,
    output logic              tone
);
    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state;
    logic               ready;
    logic [DUR_W-1:0]   remaining;
    logic [ACC_W-1:0]   acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            note_out  <= '0;
            note_done <= 1'b0;
            remaining <= '0;
            acc       <= '0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (nif.new_note) begin
                        note_out  <= nif.note;
                        remaining <= nif.duration;
                        // A zero-length note completes without ever leaving IDLE
                        if (nif.duration == '0) begin
                            note_done <= 1'b1;
                        end else begin
                            state <= PLAY;
                            ready <= 1'b0;
                        end
                    end
                end
                PLAY: begin
                    if (play_enable) begin
                        if (beat && remaining == DUR_W'(1)) begin
                            state     <= IDLE;
                            ready     <= 1'b1;
                            note_done <= 1'b1;
                            remaining <= '0;
                            acc       <= '0;
                        end else begin
                            if (beat) begin
                                remaining <= remaining - 1'b1;
                            end
                            if (note_out != '0) begin
                                acc <= acc + freq_step;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nif.player_ready = ready;
    assign tone = (state == PLAY) && play_enable && (note_out != '0) && acc[ACC_W-1];

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - directed scoreboard bench for note_player
module tb_note_player;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ACC_W  = 20;

    typedef struct {
        int               cyc;
        logic [NOTE_W-1:0] note;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              play_enable;
    logic              beat;
    logic [ACC_W-1:0]  freq_step;
    logic [NOTE_W-1:0] note_out;
    logic              note_done;
    logic              tone;

    note_player_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) nif ();

    note_player #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .nif         (nif),
        .play_enable (play_enable),
        .beat        (beat),
        .freq_step   (freq_step),
        .note_out    (note_out),
        .note_done   (note_done),
        .tone        (tone)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   a_edge = 0;
    int   bper   = 8;
    int   act    = 0;
    logic busy   = 1'b0;
    logic [NOTE_W-1:0] tnote = '0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the completion pulse is matched against the scoreboard front
    task automatic tick();
        logic due;
        exp_t e;
        @(posedge clk);
        #1;
        due = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("note_done", {31'd0, note_done}, {31'd0, due});
        if (due) begin
            e = sb.pop_front();
            chk("done_note_out", {26'd0, note_out}, {26'd0, e.note});
            chk("done_ready", {31'd0, nif.player_ready}, 32'd1);
            busy = 1'b0;
        end
    endtask

    task automatic offer(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d,
                         input int extra, input logic b);
        nif.new_note = 1'b1;
        nif.note     = n;
        nif.duration = d;
        beat         = b;
        a_edge       = cyc + 1;
        act          = 0;
        tnote        = n;
        sb.push_back('{cyc: a_edge + int'(d) * bper + extra, note: n});
        busy = (d != '0);
        tick();
        nif.new_note = 1'b0;
        beat         = 1'b0;
        chk("accept_ready", {31'd0, nif.player_ready}, {31'd0, (d == '0)});
    endtask

    // Beat strobe every bper cycles from acceptance; tone expected from enabled-edge count
    task automatic run(input int n);
        logic exp_tone;
        for (int i = 0; i < n; i++) begin
            beat = (((cyc + 1 - a_edge) % bper) == 0);
            tick();
            if (busy && play_enable) act++;
            exp_tone = busy && play_enable && (tnote != '0) && act[3];
            chk("tone", {31'd0, tone}, {31'd0, exp_tone});
            chk("ready", {31'd0, nif.player_ready}, {31'd0, !busy});
        end
        beat = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        play_enable  = 1'b1;
        beat         = 1'b0;
        freq_step    = 20'h10000;
        nif.new_note = 1'b0;
        nif.note     = '0;
        nif.duration = '0;

        // T1 reset
        repeat (4) tick();
        reset = 1'b1;
        chk("rst_ready", {31'd0, nif.player_ready}, 32'd1);
        chk("rst_done", {31'd0, note_done}, 32'd0);
        chk("rst_tone", {31'd0, tone}, 32'd0);
        chk("rst_note_out", {26'd0, note_out}, 32'd0);
        run(3);

        // T2 three-beat note, beat coincident with acceptance not counted
        bper = 8;
        offer(6'd10, 6'd3, 0, 1'b1);
        run(24);
        run(2);
        chk("note_out_hold", {26'd0, note_out}, 32'd10);

        // T3 zero duration
        offer(6'd5, 6'd0, 0, 1'b0);
        run(3);
        chk("zero_note_out", {26'd0, note_out}, 32'd5);

        // T4 pause across five beats
        offer(6'd10, 6'd3, 5 * 8, 1'b0);
        run(8);
        play_enable = 1'b0;
        run(40);
        play_enable = 1'b1;
        run(16);
        run(2);

        // T5 new_note while playing is ignored
        offer(6'd10, 6'd3, 0, 1'b0);
        run(5);
        nif.new_note = 1'b1;
        nif.note     = 6'd20;
        nif.duration = 6'd1;
        run(1);
        nif.new_note = 1'b0;
        chk("ignored_note_out", {26'd0, note_out}, 32'd10);
        run(18);
        run(2);

        // T6 async reset mid-note with tone high, then a rest note
        offer(6'd10, 6'd3, 0, 1'b0);
        run(12);
        chk("pre_reset_tone", {31'd0, tone}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        busy = 1'b0;
        chk("arst_ready", {31'd0, nif.player_ready}, 32'd1);
        chk("arst_done", {31'd0, note_done}, 32'd0);
        chk("arst_tone", {31'd0, tone}, 32'd0);
        chk("arst_note_out", {26'd0, note_out}, 32'd0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        bper = 4;
        offer(6'd0, 6'd2, 0, 1'b0);
        run(8);
        run(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
